// File: rtl/cache_ram_mp.sv
// ---------------------------------------------------------------------------
// cache_ram_mp
//
// Multi-read-port storage array for the L1 I/D cache tag+data ways.
// One bit-masked write port and NRD independent synchronous read ports.
// A sequential flush engine zeroes every entry after reset or on request, so
// the array itself carries no reset and can map to block RAM.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active LOW (outputs and FSM only)
//   we          write enable (ignored while flushing)
//   w_index     write address
//   w_mask      per-bit write mask, 1 = update that bit
//   data_in     write data
//   re          per-port read enable, one bit per read port
//   r_index     packed read addresses, port k at [k*IDX_W +: IDX_W]
//   data_out    packed read data, port k at [k*DATA_W +: DATA_W]
//   flush_req   start a full-array clear (honoured only in IDLE)
//   flush_busy  clear in progress; writes dropped, enabled reads return 0
//   flush_done  one-cycle pulse after the clear completes
//
// Build option
//   CACHE_RAM_MP_FWD_EN  when defined, a read enabled in the same cycle as an
//                        accepted write to the same index returns the merged
//                        post-write value; otherwise reads are read-first.
// ---------------------------------------------------------------------------
module cache_ram_mp #(
  parameter int DATA_W = 151,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        w_index,
  input  logic [DATA_W-1:0]       w_mask,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [NRD-1:0]          re,
  input  logic [NRD*IDX_W-1:0]    r_index,
  output logic [NRD*DATA_W-1:0]   data_out,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    flush_done
);

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

  // Bitwise merge of new data into an existing entry under a write mask.
  function automatic logic [DATA_W-1:0] merge_write(
    input logic [DATA_W-1:0] new_data,
    input logic [DATA_W-1:0] mask,
    input logic [DATA_W-1:0] old_data
  );
    return (new_data & mask) | (old_data & ~mask);
  endfunction

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [NRD*DATA_W-1:0] rd_q, rd_d;

  logic                  busy;
  logic                  wr_acc;
  logic [DATA_W-1:0]     wr_old;
  logic [DATA_W-1:0]     wr_merged;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [IDX_W-1:0]      r_idx;

  assign busy       = (state_q == ST_FLUSH);
  assign flush_busy = busy;
  assign flush_done = (state_q == ST_DONE);
  assign data_out   = rd_q;

  // -------------------------------------------------------------------------
  // Flush FSM and clear counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FLUSH: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        // flush_req deliberately ignored here; the clear just finished
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Array write port: the flush engine owns the port while busy; otherwise a
  // masked read-modify-write of the addressed entry. The IDLE->FLUSH cycle
  // still performs the user write, the clear overwrites it later.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_acc    = we && !busy;
    wr_old    = mem[w_index];
    wr_merged = merge_write(data_in, w_mask, wr_old);
    // rst gating keeps the array untouched while the block is held in reset
    mem_we    = rst && (busy || wr_acc);
    mem_waddr = busy ? cnt_q : w_index;
    mem_wdata = busy ? '0 : wr_merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports: one registered output slice per port, held when not enabled.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_d  = rd_q;
    r_idx = '0;
    for (int k = 0; k < NRD; k++) begin
      r_idx = r_index[k*IDX_W +: IDX_W];
      if (re[k]) begin
        if (busy) begin
          rd_d[k*DATA_W +: DATA_W] = '0;
        end else begin
`ifdef CACHE_RAM_MP_FWD_EN
          if (wr_acc && (r_idx == w_index)) begin
            rd_d[k*DATA_W +: DATA_W] = wr_merged;
          end else begin
            rd_d[k*DATA_W +: DATA_W] = mem[r_idx];
          end
`else
          rd_d[k*DATA_W +: DATA_W] = mem[r_idx];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

endmodule

// File: tb/tb_cache_ram_mp.sv
// ---------------------------------------------------------------------------
// tb_cache_ram_mp
//
// Directed self-checking bench for cache_ram_mp with default parameters
// (DATA_W=151, DEPTH=64, NRD=2). Inputs change and outputs are sampled 1 time
// unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_cache_ram_mp;

  localparam int DATA_W = 151;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
  localparam int NRD    = 2;

  logic                  clk;
  logic                  rst;
  logic                  we;
  logic [IDX_W-1:0]      w_index;
  logic [DATA_W-1:0]     w_mask;
  logic [DATA_W-1:0]     data_in;
  logic [NRD-1:0]        re;
  logic [NRD*IDX_W-1:0]  r_index;
  logic [NRD*DATA_W-1:0] data_out;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_done;

  int n_checks;
  int n_fail;

  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] low8;
  logic [DATA_W-1:0] v1234;
  logic [DATA_W-1:0] vabcd;
  logic [DATA_W-1:0] zero;
  logic [DATA_W-1:0] p0, p1;

  cache_ram_mp #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .NRD   (NRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .w_index   (w_index),
    .w_mask    (w_mask),
    .data_in   (data_in),
    .re        (re),
    .r_index   (r_index),
    .data_out  (data_out),
    .flush_req (flush_req),
    .flush_busy(flush_busy),
    .flush_done(flush_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign p0 = data_out[DATA_W-1:0];
  assign p1 = data_out[2*DATA_W-1:DATA_W];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [IDX_W-1:0] i0,
                        input logic [IDX_W-1:0] i1);
    re      = en;
    r_index = {i1, i0};
  endtask

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] m);
    we      = 1'b1;
    w_index = idx;
    data_in = d;
    w_mask  = m;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (data_out !== '0) begin
      n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out);
    end
    n_checks++;
    if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b want busy=1 done=0", flush_busy, flush_done);
    end
    rst = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++;
      if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin
        n_fail++; $display("FAIL init_busy cycle %0d: busy=%b done=%b want 1/0", i, flush_busy, flush_done);
      end
      step();
    end
    n_checks++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b1) begin
      n_fail++; $display("FAIL init_done_pulse: busy=%b done=%b want 0/1", flush_busy, flush_done);
    end
    step();
    n_checks++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
      n_fail++; $display("FAIL init_idle: busy=%b done=%b want 0/0", flush_busy, flush_done);
    end
    set_rd(2'b11, 6'd0, 6'd31);
    step();
    n_checks++;
    if (p0 !== zero || p1 !== zero) begin
      n_fail++; $display("FAIL init_read_0_31: got %h / %h want 0", p0, p1);
    end
    set_rd(2'b01, 6'd63, 6'd0);
    step();
    n_checks++;
    if (p0 !== zero) begin
      n_fail++; $display("FAIL init_read_63: got %h want 0", p0);
    end
    re = 2'b00;
  endtask

  task automatic test_write_read();
    do_write(6'd5, ones, ones);
    step();
    we = 1'b0;
    set_rd(2'b11, 6'd5, 6'd5);
    step();
    re = 2'b00;
    n_checks++;
    if (p0 !== ones || p1 !== ones) begin
      n_fail++; $display("FAIL write_read_idx5: got %h / %h want %h", p0, p1, ones);
    end
  endtask

  task automatic test_masked_write();
    do_write(6'd5, zero, low8);
    step();
    we = 1'b0;
    set_rd(2'b01, 6'd5, 6'd0);
    step();
    re = 2'b00;
    n_checks++;
    if (p0 !== ~low8) begin
      n_fail++; $display("FAIL masked_write: got %h want %h", p0, ~low8);
    end
    n_checks++;
    if (p1 !== ones) begin
      n_fail++; $display("FAIL hold_port1: got %h want %h", p1, ones);
    end
  endtask

  task automatic test_forwarding();
    logic [DATA_W-1:0] exp_same;
`ifdef CACHE_RAM_MP_FWD_EN
    exp_same = v1234;
`else
    exp_same = zero;
`endif
    do_write(6'd9, v1234, ones);
    set_rd(2'b01, 6'd9, 6'd0);
    step();
    we = 1'b0;
    n_checks++;
    if (p0 !== exp_same) begin
      n_fail++; $display("FAIL same_cycle_rw: got %h want %h", p0, exp_same);
    end
    step();
    re = 2'b00;
    n_checks++;
    if (p0 !== v1234) begin
      n_fail++; $display("FAIL after_write_read: got %h want %h", p0, v1234);
    end
  endtask

  task automatic test_back_to_back();
    set_rd(2'b11, 6'd9, 6'd5);
    step();
    set_rd(2'b11, 6'd5, 6'd9);
    n_checks++;
    if (p0 !== v1234 || p1 !== ~low8) begin
      n_fail++; $display("FAIL b2b_first: got %h / %h want %h / %h", p0, p1, v1234, ~low8);
    end
    step();
    re = 2'b00;
    n_checks++;
    if (p0 !== ~low8 || p1 !== v1234) begin
      n_fail++; $display("FAIL b2b_second: got %h / %h want %h / %h", p0, p1, ~low8, v1234);
    end
  endtask

  task automatic test_flush_req();
    flush_req = 1'b1;
    do_write(6'd3, ones, ones);
    step();
    flush_req = 1'b0;
    we        = 1'b0;
    set_rd(2'b01, 6'd3, 6'd0);
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin
        n_fail++; $display("FAIL req_busy cycle %0d: busy=%b done=%b want 1/0", i + 1, flush_busy, flush_done);
      end
      if (i == 1) begin
        n_checks++;
        if (p0 !== zero) begin
          n_fail++; $display("FAIL read_during_flush: got %h want 0", p0);
        end
        re = 2'b00;
      end
      if (i == 10) do_write(6'd2, ones, ones);
      if (i == 11) we = 1'b0;
      step();
    end
    n_checks++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b1) begin
      n_fail++; $display("FAIL req_done_pulse: busy=%b done=%b want 0/1", flush_busy, flush_done);
    end
    // flush_req in DONE is ignored, a write in DONE is accepted
    flush_req = 1'b1;
    do_write(6'd7, vabcd, ones);
    step();
    flush_req = 1'b0;
    we        = 1'b0;
    n_checks++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
      n_fail++; $display("FAIL req_in_done_ignored: busy=%b done=%b want 0/0", flush_busy, flush_done);
    end
    set_rd(2'b11, 6'd3, 6'd2);
    step();
    n_checks++;
    if (p0 !== zero || p1 !== zero) begin
      n_fail++; $display("FAIL flushed_idx3_dropped_idx2: got %h / %h want 0", p0, p1);
    end
    set_rd(2'b01, 6'd7, 6'd0);
    step();
    re = 2'b00;
    n_checks++;
    if (p0 !== vabcd) begin
      n_fail++; $display("FAIL write_in_done: got %h want %h", p0, vabcd);
    end
  endtask

  task automatic test_rst_mid_flush();
    set_rd(2'b10, 6'd0, 6'd7);
    step();
    re = 2'b00;
    n_checks++;
    if (p1 !== vabcd) begin
      n_fail++; $display("FAIL preload_port1: got %h want %h", p1, vabcd);
    end
    do_write(6'd40, ones, ones);
    step();
    we        = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 1; i < 20; i++) begin
      n_checks++;
      if (p1 !== vabcd) begin
        n_fail++; $display("FAIL hold_port1_flush cycle %0d: got %h want %h", i, p1, vabcd);
      end
      step();
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (flush_busy !== 1'b1 || flush_done !== 1'b0 || data_out !== '0) begin
      n_fail++; $display("FAIL mid_flush_reset: busy=%b done=%b data_out=%h want 1/0/0", flush_busy, flush_done, data_out);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++;
      if (flush_busy !== 1'b1 || p1 !== zero) begin
        n_fail++; $display("FAIL restart_busy cycle %0d: busy=%b port1=%h want 1/0", i, flush_busy, p1);
      end
      step();
    end
    n_checks++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b1) begin
      n_fail++; $display("FAIL restart_done_pulse: busy=%b done=%b want 0/1", flush_busy, flush_done);
    end
    step();
    set_rd(2'b11, 6'd7, 6'd40);
    step();
    re = 2'b00;
    n_checks++;
    if (p0 !== zero || p1 !== zero) begin
      n_fail++; $display("FAIL restart_cleared: got %h / %h want 0", p0, p1);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ones      = '1;
    zero      = '0;
    low8      = DATA_W'(8'hFF);
    v1234     = DATA_W'(16'h1234);
    vabcd     = DATA_W'(16'hABCD);
    rst       = 1'b1;
    we        = 1'b0;
    w_index   = '0;
    w_mask    = '0;
    data_in   = '0;
    re        = '0;
    r_index   = '0;
    flush_req = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_masked_write();
    test_forwarding();
    test_back_to_back();
    test_flush_req();
    test_rst_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ram_mp.md
# cache_ram_mp

Parametrised multi-read-port cache storage array for the L1 I/D cache tag+data ways. One masked write port and `NRD` independent synchronous read ports. An internal sequential flush engine clears every entry after reset or on request, so the array itself needs no reset fan-out and maps to block RAM. Optional same-cycle write-to-read forwarding.

## Interface
Parameters:
- `DATA_W`, 151, entry width in bits
- `DEPTH`, 64, number of entries; power of two, ≥ 2
- `IDX_W`, `$clog2(DEPTH)`, index width
- `NRD`, 2, number of read ports, 1..4

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `we`  in  1  write enable
- `w_index`  in  IDX_W  write address
- `w_mask`  in  DATA_W  per-bit write mask; 1 = update the bit
- `data_in`  in  DATA_W  write data
- `re`  in  NRD  per-port read enable
- `r_index`  in  NRD*IDX_W  read addresses; port k uses bits [k*IDX_W +: IDX_W]
- `data_out`  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- `flush_req`  in  1  start a full-array clear
- `flush_busy`  out  1  clear in progress; writes are ignored
- `flush_done`  out  1  one-cycle pulse when a clear completes

## Operation
- FSM states: FLUSH, DONE, IDLE. Reset state is FLUSH with clear counter `cnt` = 0.
- FLUSH:
  - each cycle writes all-zero to `data[cnt]` and increments `cnt`
  - on the edge that clears `cnt == DEPTH-1`: go to DONE, `cnt` wraps to 0
  - `flush_busy` = 1; `we` and `flush_req` are ignored
- DONE: `flush_done` = 1, `flush_busy` = 0; the next edge goes to IDLE. Writes are accepted. `flush_req` is ignored.
- IDLE: `flush_req` = 1 goes to FLUSH with `cnt` = 0. Any `we` in the same cycle is still performed. Otherwise stay in IDLE.
- Write (DONE or IDLE, `we` = 1): `data[w_index] <= (data_in & w_mask) | (data[w_index] & ~w_mask)`.
- Read, port k:
  - `re[k]` = 1: the `data_out` slice is loaded with the entry at `r_index` slice k
  - `re[k]` = 0: the slice holds its previous value
  - ports are fully independent; any two ports may address the same index
- While `flush_busy` = 1, every enabled read port loads all-zero regardless of index.
- Array contents are not touched by `rst`; only outputs and FSM state are reset.
- Asserting `rst` mid-flush aborts the clear and restarts it from index 0 after release.

## Timing
- Reset values: `data_out` = 0 on all ports, `flush_busy` = 1, `flush_done` = 0, state FLUSH, `cnt` = 0.
- Read latency is 1 cycle: index sampled at edge N, data valid after edge N.
- A write at edge N is visible to any read sampled at edge N+1 or later.
- Flush duration:
  - `flush_busy` is high for exactly DEPTH cycles
  - `flush_done` is high for 1 cycle
  - the first write is accepted in the `flush_done` cycle
- After reset release, the array is usable after DEPTH edges.

## Configuration
- `CACHE_RAM_MP_FWD_EN` defined: a read enabled in the same cycle as an accepted write to the same index returns the merged post-write value, `(data_in & w_mask) | (old & ~w_mask)`. This applies to every port independently.
- Not defined: read-first behaviour; a same-index read returns the pre-write contents.
- Flush-cycle reads return zero in both builds.

## Test plan
- Reset, then DEPTH=64 idle cycles -> `flush_busy` high for cycles 1..64, `flush_done` pulses in cycle 65; reads of indices 0, 31, 63 return 0.
- Write index 5 with `data_in` = all-ones and mask = all-ones, then on the next cycle read ports 0 and 1 at index 5 -> both return all-ones one cycle later.
- Masked write of 0 to index 5 with `w_mask` = low 8 bits -> read returns all-ones except bits [7:0] = 0.
- Same-cycle write and read of index 9, data 0x1234, full mask, old value 0:
  - with `CACHE_RAM_MP_FWD_EN`: `data_out` = 0x1234
  - without: `data_out` = 0
  - following read returns 0x1234 in both builds
- `flush_req` in IDLE together with `we` to index 3 -> write lands, then is cleared; 64 busy cycles; read of index 3 = 0; writes issued during busy are dropped.
- `rst` asserted at flush cycle 20 and released -> `flush_busy` stays high for a full 64 cycles from release; `re` = 0 on a port holds its `data_out` unchanged throughout.
